// File: rtl/rd_cla8_pipe_pkg.sv
// Shared carry-state codes, widths and stage bundles for the
// pipelined 8-bit recursive-doubling carry-lookahead adder.
package rd_cla8_pipe_pkg;

  localparam int WIDTH  = 8;
  localparam int LEVELS = 3;
  localparam int STAGES = LEVELS + 1;

  localparam logic [1:0] KPG_K = 2'b00;
  localparam logic [1:0] KPG_P = 2'b01;
  localparam logic [1:0] KPG_G = 2'b11;

  typedef struct packed {
    logic [2*WIDTH-1:0] kpg;
    logic [WIDTH-1:0]   p;
    logic               cin;
    logic               valid;
  } lvl_t;

  typedef struct packed {
    logic [2*WIDTH-1:0] kpg;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic               ovf;
    logic               valid;
  } res_t;

  function automatic logic [1:0] classify(
    input logic a,
    input logic b
  );
    logic [1:0] r;
    r = KPG_P;
    unique case (1'b1)
      (a & b):   r = KPG_G;
      (~a & ~b): r = KPG_K;
      default:   r = KPG_P;
    endcase
    return r;
  endfunction

  function automatic logic has_code(
    input logic [2*WIDTH-1:0] kpg,
    input logic [1:0]         code
  );
    logic r;
    r = 1'b0;
    for (int i = 0; i < WIDTH; i++)
      if (kpg[2*i +: 2] == code)
        r = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rd_cla8_pipe_if.sv
// Operand/result bundle for rd_cla8_pipe, including the
// pipeline advance enable.
interface rd_cla8_pipe_if;
  import rd_cla8_pipe_pkg::*;

  logic             ce;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output ce, in_valid, a, b, cin,
    input  out_valid, sum, cout, ovf
  );

  modport slave (
    input  ce, in_valid, a, b, cin,
    output out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/rd_kpg_combine.sv
// Carry-state operator x o y: x (more significant) wins
// unless it propagates, in which case y passes through.
module rd_kpg_combine
  import rd_cla8_pipe_pkg::*;
(
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [1:0] z
);

  assign z = (x == KPG_P) ? y : x;

endmodule

// File: rtl/rd_cla8_pipe.sv
// Four-register pipelined 8-bit recursive-doubling CLA:
// classify, three doubling levels, then sum/cout/ovf.
module rd_cla8_pipe
  import rd_cla8_pipe_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  rd_cla8_pipe_if.slave  io
);

  logic [2*WIDTH-1:0]         kpg0;
  logic [WIDTH-1:0]           p0;
  lvl_t                       st [1:LEVELS];
  res_t                       r4;
  logic [LEVELS-1:0][2*WIDTH-1:0] cmb;
  logic [WIDTH:0]             c;
  logic [WIDTH-1:0]           sum3;

  // Bit 0 absorbs carry-in so the doubling tree sees no cin.
  always_comb begin
    kpg0 = '0;
    p0   = io.a ^ io.b;
    for (int i = 0; i < WIDTH; i++)
      kpg0[2*i +: 2] = classify(io.a[i], io.b[i]);
    if (kpg0[1:0] == KPG_P)
      kpg0[1:0] = io.cin ? KPG_G : KPG_K;
  end

  for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
    localparam int DIST = 1 << j;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= DIST) begin : g_cmb
        rd_kpg_combine u_cmb (
          .x (st[j+1].kpg[2*i +: 2]),
          .y (st[j+1].kpg[2*(i-DIST) +: 2]),
          .z (cmb[j][2*i +: 2])
        );
      end else begin : g_pass
        assign cmb[j][2*i +: 2] = st[j+1].kpg[2*i +: 2];
      end
    end
  end

  always_comb begin
    c    = '0;
    c[0] = st[LEVELS].cin;
    for (int i = 0; i < WIDTH; i++)
      c[i+1] = (cmb[LEVELS-1][2*i +: 2] == KPG_G);
    sum3 = st[LEVELS].p ^ c[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= LEVELS; k++)
        st[k] <= '0;
      r4 <= '0;
    end else if (io.ce) begin
      st[1] <= '{kpg: kpg0, p: p0,
                 cin: io.cin, valid: io.in_valid};
      for (int k = 2; k <= LEVELS; k++)
        st[k] <= '{kpg: cmb[k-2], p: st[k-1].p,
                   cin: st[k-1].cin, valid: st[k-1].valid};
      r4 <= '{kpg: cmb[LEVELS-1], sum: sum3,
              cout: c[WIDTH],
              ovf: c[WIDTH] ^ c[WIDTH-1],
              valid: st[LEVELS].valid};
    end
  end

  assign io.out_valid = r4.valid;
  assign io.sum       = r4.sum;
  assign io.cout      = r4.cout;
  assign io.ovf       = r4.ovf;

  a_no_illegal: assert property (@(posedge clk) disable iff (reset)
    !has_code(st[1].kpg, 2'b10) && !has_code(st[2].kpg, 2'b10) &&
    !has_code(st[3].kpg, 2'b10) && !has_code(r4.kpg, 2'b10));

  a_resolved: assert property (@(posedge clk) disable iff (reset)
    r4.valid |-> !has_code(r4.kpg, KPG_P));

endmodule

// File: tb/tb_rd_cla8_pipe.sv
// Randomized and directed checks of rd_cla8_pipe against an
// arithmetic reference fed through a 4-deep delay model.
module tb_rd_cla8_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rd_cla8_pipe_if io ();

  rd_cla8_pipe dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  typedef struct {
    bit       v;
    bit [7:0] s;
    bit       co;
    bit       ov;
  } exp_t;

  exp_t pipe [4];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_add(input bit [7:0] a,
                                   input bit [7:0] b,
                                   input bit cin);
    exp_t     r;
    bit [8:0] t;
    t    = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    r.v  = 1'b1;
    r.s  = t[7:0];
    r.co = t[8];
    r.ov = (a[7] == b[7]) && (t[7] != a[7]);
    return r;
  endfunction

  task automatic step(input bit rst, input bit ce, input bit v,
                      input bit [7:0] a, input bit [7:0] b,
                      input bit cin);
    exp_t nb;
    reset       = rst;
    io.ce       = ce;
    io.in_valid = v;
    io.a        = a;
    io.b        = b;
    io.cin      = cin;
    nb          = '{0, 0, 0, 0};
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 4; k++) pipe[k] = nb;
    end else if (ce) begin
      for (int k = 3; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0] = v ? ref_add(a, b, cin) : nb;
    end
    #1;
    check("out_valid", io.out_valid, pipe[3].v);
    if (pipe[3].v) begin
      check("sum",  io.sum,  pipe[3].s);
      check("cout", io.cout, pipe[3].co);
      check("ovf",  io.ovf,  pipe[3].ov);
    end
    if (rst) begin
      check("rst_sum",  io.sum,  0);
      check("rst_cout", io.cout, 0);
      check("rst_ovf",  io.ovf,  0);
    end
  endtask

  task automatic bubble();
    step(0, 1, 0, 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic op(input bit [7:0] a, input bit [7:0] b,
                    input bit cin);
    step(0, 1, 1, a, b, cin);
  endtask

  task automatic directed(input string tag,
                          input bit [7:0] a, input bit [7:0] b,
                          input bit cin, input bit [7:0] es,
                          input bit ec, input bit eo);
    op(a, b, cin);
    repeat (3) bubble();
    check({tag, "_v"},    io.out_valid, 1);
    check({tag, "_sum"},  io.sum,  es);
    check({tag, "_cout"}, io.cout, ec);
    check({tag, "_ovf"},  io.ovf,  eo);
  endtask

  int issued;

  initial begin
    for (int k = 0; k < 4; k++) pipe[k] = '{0, 0, 0, 0};
    step(1, 0, 1, 8'hFF, 8'hFF, 1);
    step(1, 1, 1, 8'h12, 8'h34, 0);
    repeat (2) bubble();

    directed("ff_01",  8'hFF, 8'h01, 0, 8'h00, 1, 0);
    directed("7f_01",  8'h7F, 8'h01, 0, 8'h80, 0, 1);
    directed("80_80",  8'h80, 8'h80, 0, 8'h00, 1, 1);
    directed("aa_55c", 8'hAA, 8'h55, 1, 8'h00, 1, 0);
    directed("aa_55",  8'hAA, 8'h55, 0, 8'hFF, 0, 0);

    issued = 0;
    while (issued < 20) begin
      if ($urandom_range(0, 2) == 0) bubble();
      else begin
        op(8'($urandom), 8'($urandom), 1'($urandom));
        issued++;
      end
    end
    repeat (4) bubble();

    repeat (3) op(8'($urandom), 8'($urandom), 1'($urandom));
    repeat (3)
      step(0, 0, 1, 8'($urandom), 8'($urandom), 1'($urandom));
    repeat (5) bubble();

    op(8'h01, 8'h02, 0);
    repeat (2) op(8'($urandom), 8'($urandom), 1'($urandom));
    step(1, 1, 1, 8'hFF, 8'hFF, 1);
    repeat (3) bubble();
    directed("post_rst", 8'h40, 8'h40, 1, 8'h81, 0, 1);
    repeat (2) bubble();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rd_cla8_pipe.md
# rd_cla8_pipe

Pipelined 8-bit recursive-doubling carry-lookahead adder datapath. It accepts operands and carry-in, classifies each bit position as kill/propagate/generate, and resolves carries in log2(8)=3 doubling levels. Each level is separated by a pipeline register bank of the same style as the existing 8/16/2/1-bit pipeline register stage. It produces sum, carry-out and signed overflow with a fixed 4-cycle latency. It feeds the existing per-level pipeline register stage and consumes nothing upstream but the raw operands.

## Interface
Parameters: none. Width fixed at 8.

- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high; sampled on rising clk
- ce  input  1  pipeline advance enable; 0 = every register holds
- in_valid  input  1  a/b/cin are a valid operation this cycle
- a  input  8  operand A (unsigned or two's complement)
- b  input  8  operand B
- cin  input  1  carry-in
- out_valid  output  1  sum/cout/ovf correspond to a valid operation
- sum  output  8  a+b+cin mod 256
- cout  output  1  carry out of bit 7
- ovf  output  1  signed overflow = carry into bit 7 XOR cout

## Operation
- Carry state per bit uses a 2-bit code: K=2'b00 (kill), P=2'b01 (propagate), G=2'b11 (generate). 2'b10 is illegal and is never produced.
- Classification: a_i&b_i gives G; ~a_i&~b_i gives K; otherwise P.
- Carry-in is folded into bit 0: if bit 0 is P, it becomes G when cin=1 and K when cin=0.
- Combine x∘y (x more significant, y less significant): result is x if x∈{K,G}, else y.
- Level j (distance 1, 2, 4): d'[i] = d[i]∘d[i−dist] for i≥dist; otherwise d'[i] = d[i].
- After level 3, no P remains. Carry into bit i+1 is c[i+1] = (d[i]==G), with c[0]=cin.
- Outputs: sum_i = p_i ^ c[i], where p_i = a_i^b_i is carried down the pipe. cout = c[8]. ovf = c[7]^c[8].
- Pipeline registers:
  - R1: kpg[15:0], p[7:0], cin, valid
  - R2: after dist-1 combine
  - R3: after dist-2 combine
  - R4: after dist-4 combine, plus sum, cout, ovf, valid
- The valid bit travels with its data. Data registers load on every ce=1 edge regardless of valid. Outputs are checked only when out_valid=1.

## Timing
- Latency: an operation presented with in_valid=1 and ce=1 at edge k appears with out_valid=1 after edge k+3, i.e. 4 registered stages.
- Throughput: one operation per ce=1 cycle. Back-to-back operations never interact.
- ce=0: all R1–R4 hold, including valid bits. Outputs stay stable. Input ignored.
- reset=1 at an edge: all registers clear to 0, so out_valid=0, sum=8'h00, cout=0, ovf=0. Reset overrides ce.
- In-flight operations are discarded at reset, with no partial output.
- First valid output after reset deasserts: no earlier than 4 edges after the first accepted in_valid.
- Bubble (in_valid=0, ce=1): propagates as out_valid=0 four cycles later.

## Structure
- Shared package holds the carry-state codes (K/P/G localparams) and the stage count (3 levels, 4 registers).
- One sub-module: rd_kpg_combine. It is the combinational 2-bit ∘ operator and is instantiated per bit per level.
- Registers are built from the existing 16-bit, 8-bit, 2-bit and 1-bit DFF modules, extended with a hold (ce) path, or from a ce-gated equivalent with synchronous reset.
- Assertion: no kpg field ever equals 2'b10. No P is present in R4 when valid.

## Test plan
- 8'hFF + 8'h01, cin=0 → 4 cycles later: sum=8'h00, cout=1, ovf=0.
- 8'h7F + 8'h01, cin=0 → sum=8'h80, cout=0, ovf=1. Then 8'h80 + 8'h80 → sum=8'h00, cout=1, ovf=1.
- 8'hAA + 8'h55, cin=1 (full propagate chain) → sum=8'h00, cout=1, ovf=0. Same operands with cin=0 → sum=8'hFF, cout=0.
- Stream of 20 random back-to-back valid operations with interleaved bubbles → outputs match a reference model in order at latency 4. out_valid pattern equals the in_valid pattern delayed by 4.
- Hold ce=0 for 3 cycles with 3 operations in flight → outputs frozen. After ce returns to 1, results emerge in order with no loss or duplication.
- Assert reset for 1 cycle with 3 operations in flight → next edge all outputs are 0 and out_valid stays 0 until a new operation is 4 cycles through.
